// File: rtl/stream_golden_checker.sv
// Golden-vector stream checker: compares a valid-qualified sample stream against a
// runtime-loadable golden block, tracks framing and mismatches, and reports pass/fail.
module stream_golden_checker #(
  parameter int unsigned W           = 1,
  parameter int unsigned DEPTH       = 96,
  parameter int unsigned PASS_BLOCKS = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned AW          = $clog2(DEPTH)
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             gold_we,
  input  logic [AW-1:0]    gold_addr,
  input  logic [W-1:0]     gold_data,
  input  logic             arm,
  input  logic             s_valid,
  input  logic             s_first,
  input  logic [W-1:0]     s_data,
  output logic             pass,
  output logic             fail,
  output logic             align_err,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] block_cnt,
  output logic [1:0]       state
);

  localparam int unsigned GW = $clog2(PASS_BLOCKS + 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StPass = 2'b10,
    StFail = 2'b11
  } state_e;

  logic [W-1:0]     gold_q [DEPTH];
  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             blk_err_q, blk_err_d;
  logic [GW-1:0]    good_q, good_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             align_q, align_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic [CNT_W-1:0] blk_q, blk_d;

  logic [AW-1:0]    eff_idx;
  logic             miss;
  logic             misalign;
  logic             err;
  logic [GW-1:0]    good_inc;

  // Golden memory: no reset, contents survive rst and arm; out-of-range writes dropped.
  always_ff @(posedge clk_ref) begin
    if (gold_we && (32'(gold_addr) < DEPTH)) begin
      gold_q[gold_addr] <= gold_data;
    end
  end

  // Status and FSM state registers with synchronous reset.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      blk_err_q <= 1'b0;
      good_q    <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      align_q   <= 1'b0;
      mis_q     <= '0;
      blk_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      blk_err_q <= blk_err_d;
      good_q    <= good_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      align_q   <= align_d;
      mis_q     <= mis_d;
      blk_q     <= blk_d;
    end
  end

  // Next-state: arm restarts from any state; otherwise compare while in RUN or PASS.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    blk_err_d = blk_err_q;
    good_d    = good_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    align_d   = align_q;
    mis_d     = mis_q;
    blk_d     = blk_q;
    eff_idx   = s_first ? '0 : idx_q;
    // Compare uses the pre-edge memory contents, so a same-cycle write is not seen.
    miss      = (s_data != gold_q[eff_idx]);
    misalign  = s_first && (idx_q != '0);
    err       = blk_err_q || miss || misalign;
    good_inc  = (good_q < GW'(PASS_BLOCKS)) ? good_q + GW'(1) : good_q;

    if (arm) begin
      state_d   = StRun;
      idx_d     = '0;
      blk_err_d = 1'b0;
      good_d    = '0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      align_d   = 1'b0;
      mis_d     = '0;
      blk_d     = '0;
    end else if (s_valid && (state_q == StRun || state_q == StPass)) begin
      if (miss && (mis_q != '1)) begin
        mis_d = mis_q + CNT_W'(1);
      end
      if (misalign) begin
        align_d = 1'b1;
      end
      if (eff_idx == AW'(DEPTH - 1)) begin
        if (blk_q != '1) begin
          blk_d = blk_q + CNT_W'(1);
        end
        idx_d     = '0;
        blk_err_d = 1'b0;
        if (err) begin
          good_d  = '0;
          state_d = StFail;
          fail_d  = 1'b1;
          pass_d  = 1'b0;
        end else begin
          good_d = good_inc;
          if (state_q == StRun && good_inc == GW'(PASS_BLOCKS)) begin
            state_d = StPass;
            pass_d  = 1'b1;
          end
        end
      end else begin
        idx_d     = eff_idx + AW'(1);
        blk_err_d = err;
      end
    end
  end

  assign pass         = pass_q;
  assign fail         = fail_q;
  assign align_err    = align_q;
  assign mismatch_cnt = mis_q;
  assign block_cnt    = blk_q;
  assign state        = state_q;

endmodule
